systolic_mm_engine: RTL

- Parametrised N×N output-stationary systolic matrix-multiply engine. Computes C = A·B on whole-matrix operands, with:
  - valid/ready handshakes on both the input and output sides;
  - internal operand skewing;
  - signed or unsigned mode;
  - saturating accumulation;
  - optional accumulate-onto-previous-result for K-tiled products.
- Sits between the operand buffers and the result writeback. Successor to the fixed 3×3 array top level.

---
 rtl/systolic_pkg.sv | 65 ++++++
 rtl/systolic_mm_engine_if.sv | 29 ++
 rtl/systolic_pe.sv | 82 ++++++++
 rtl/systolic_mm_engine.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and arithmetic helpers for the systolic matrix-multiply engine.
// Helpers work on a wide signed container so one definition serves every
// DATA_WIDTH (<= 32) / OUTPUT_WIDTH (<= 64) combination; callers truncate.
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_DONE
  } state_e;

  localparam int unsigned MAX_DW = 32;
  localparam int unsigned MAX_OW = 64;

  // Two guard bits so any acc + product sum is exact before clamping.
  typedef logic signed [MAX_OW+1:0] wide_t;

  typedef struct packed {
    logic                     sat;
    logic signed [MAX_OW+1:0] val;
  } sat_res_t;

  // Sign- or zero-extend the low w bits of x.
  function automatic wide_t ext_operand(logic [MAX_DW-1:0] x, int unsigned w, logic sgn);
    wide_t mask;
    wide_t v;
    mask = (wide_t'(1) << w) - wide_t'(1);
    v    = wide_t'(x) & mask;
    if (sgn && x[5'(w - 1)]) v = v | ~mask;
    return v;
  endfunction

  // Full-precision product of two w-bit operands in the selected mode.
  function automatic wide_t ext_prod(logic [MAX_DW-1:0] a, logic [MAX_DW-1:0] b,
                                     int unsigned w, logic sgn);
    return ext_operand(a, w, sgn) * ext_operand(b, w, sgn);
  endfunction

  // acc + prod clamped to the ow-bit signed or unsigned range.
  function automatic sat_res_t sat_add(wide_t acc, wide_t prod, logic sgn, int unsigned ow);
    wide_t    sum;
    wide_t    hi;
    wide_t    lo;
    sat_res_t r;
    sum = acc + prod;
    if (sgn) begin
      hi = (wide_t'(1) << (ow - 1)) - wide_t'(1);
      lo = -(wide_t'(1) << (ow - 1));
    end else begin
      hi = (wide_t'(1) << ow) - wide_t'(1);
      lo = '0;
    end
    r.sat = 1'b0;
    r.val = sum;
    if (sum > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (sum < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_mm_engine_if.sv
// Job/result bus of the systolic engine.
// master: job source and result sink; slave: the engine.
interface systolic_mm_engine_if #(
  parameter int unsigned N            = 3,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OUTPUT_WIDTH = 16
);
  logic                                       in_valid;
  logic                                       in_ready;
  logic [0:N-1][0:N-1][DATA_WIDTH-1:0]        a;
  logic [0:N-1][0:N-1][DATA_WIDTH-1:0]        b;
  logic                                       signed_mode;
  logic                                       accumulate;
  logic [0:N-1][0:N-1][OUTPUT_WIDTH-1:0]      c;
  logic                                       out_valid;
  logic                                       out_ready;
  logic                                       overflow;
  logic                                       busy;

  modport master (
    output in_valid, a, b, signed_mode, accumulate, out_ready,
    input  in_ready, c, out_valid, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, accumulate, out_ready,
    output in_ready, c, out_valid, overflow, busy
  );
endinterface

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell.
// Ports: a_in/b_in + valids from left/top; a_out/b_out registered forwards to
// right/bottom; load/load_val preload the accumulator; acc/sat are the running
// sum and sticky saturation flag.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OUTPUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [OUTPUT_WIDTH-1:0] load_val,
  input  logic                    signed_mode,
  input  logic [DATA_WIDTH-1:0]   a_in,
  input  logic                    a_vld_in,
  input  logic [DATA_WIDTH-1:0]   b_in,
  input  logic                    b_vld_in,
  output logic [DATA_WIDTH-1:0]   a_out,
  output logic                    a_vld_out,
  output logic [DATA_WIDTH-1:0]   b_out,
  output logic                    b_vld_out,
  output logic [OUTPUT_WIDTH-1:0] acc,
  output logic                    sat
);

  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                    a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  wide_t                   prod_c, acc_ext_c;
  sat_res_t                sum_c;

  // MAC with saturation; a job load also flushes the forwarding valids.
  always_comb begin
    a_d       = a_in;
    a_vld_d   = a_vld_in;
    b_d       = b_in;
    b_vld_d   = b_vld_in;
    acc_d     = acc_q;
    sat_d     = sat_q;
    prod_c    = ext_prod(MAX_DW'(a_in), MAX_DW'(b_in), DATA_WIDTH, signed_mode);
    acc_ext_c = signed_mode ? wide_t'($signed(acc_q)) : wide_t'(acc_q);
    sum_c     = sat_add(acc_ext_c, prod_c, signed_mode, OUTPUT_WIDTH);
    if (load) begin
      acc_d   = load_val;
      sat_d   = 1'b0;
      a_vld_d = 1'b0;
      b_vld_d = 1'b0;
    end else if (a_vld_in && b_vld_in) begin
      acc_d = OUTPUT_WIDTH'(sum_c.val);
      sat_d = sat_q | sum_c.sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      a_vld_q <= 1'b0;
      b_q     <= '0;
      b_vld_q <= 1'b0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      a_vld_q <= a_vld_d;
      b_q     <= b_d;
      b_vld_q <= b_vld_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign a_out     = a_q;
  assign a_vld_out = a_vld_q;
  assign b_out     = b_q;
  assign b_vld_out = b_vld_q;
  assign acc       = acc_q;
  assign sat       = sat_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic matrix multiply, C = A*B (+ previous C).
// Ports: clk, rst_n, and the slave side of systolic_mm_engine_if carrying
// the job handshake (in_valid/in_ready, a, b, signed_mode, accumulate) and
// result handshake (out_valid/out_ready, c, overflow) plus busy.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int unsigned N            = 3,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OUTPUT_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  systolic_mm_engine_if.slave bus
);

  // Steps 0..3N-3 feed operands; step 3N-2 lets the last MAC settle.
  localparam int unsigned LAST_STEP = 3 * N - 2;
  localparam int unsigned CNT_W     = $clog2(LAST_STEP + 1);

  typedef logic [0:N-1][0:N-1][DATA_WIDTH-1:0]   opmat_t;
  typedef logic [0:N-1][0:N-1][OUTPUT_WIDTH-1:0] resmat_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  opmat_t           a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  resmat_t          c_q, c_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_c, capture_c;

  resmat_t          acc_w, load_val;
  logic [0:N-1][0:N-1] sat_w;

  logic [DATA_WIDTH-1:0] a_feed [N];
  logic [DATA_WIDTH-1:0] b_feed [N];
  logic                  a_feed_v [N];
  logic                  b_feed_v [N];
  logic [DATA_WIDTH-1:0] a_fwd [N][N];
  logic [DATA_WIDTH-1:0] b_fwd [N][N];
  logic                  a_fwd_v [N][N];
  logic                  b_fwd_v [N][N];

  // FSM, handshakes and output registers.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    in_ready_c  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    capture_c   = bus.in_valid && in_ready_c;

    case (state_q)
      S_COMPUTE: begin
        step_d = step_q + CNT_W'(1);
        if (step_q == CNT_W'(LAST_STEP)) begin
          state_d     = S_DONE;
          c_d         = acc_w;
          out_valid_d = 1'b1;
          overflow_d  = |sat_w;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (capture_c) begin
      state_d     = S_COMPUTE;
      step_d      = '0;
      a_d         = bus.a;
      b_d         = bus.b;
      sgn_d       = bus.signed_mode;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Skewed edge feeders: row i gets a[i][t-i], column i gets b[t-i][i].
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_feed[i]   = '0;
      a_feed_v[i] = 1'b0;
      b_feed[i]   = '0;
      b_feed_v[i] = 1'b0;
      for (int k = 0; k < N; k++) begin
        if ((state_q == S_COMPUTE) && (step_q == CNT_W'(i + k))) begin
          a_feed[i]   = a_q[i][k];
          a_feed_v[i] = 1'b1;
          b_feed[i]   = b_q[k][i];
          b_feed_v[i] = 1'b1;
        end
      end
    end
  end

  // A same-edge pop+capture reads the c being popped.
  assign load_val = bus.accumulate ? c_q : '0;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in, b_in;
      logic                  a_vin, b_vin;

      if (j == 0) begin : g_left
        assign a_in  = a_feed[i];
        assign a_vin = a_feed_v[i];
      end else begin : g_inner_a
        assign a_in  = a_fwd[i][j-1];
        assign a_vin = a_fwd_v[i][j-1];
      end

      if (i == 0) begin : g_top
        assign b_in  = b_feed[j];
        assign b_vin = b_feed_v[j];
      end else begin : g_inner_b
        assign b_in  = b_fwd[i-1][j];
        assign b_vin = b_fwd_v[i-1][j];
      end

      systolic_pe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .OUTPUT_WIDTH(OUTPUT_WIDTH)
      ) u_pe (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (capture_c),
        .load_val   (load_val[i][j]),
        .signed_mode(sgn_q),
        .a_in       (a_in),
        .a_vld_in   (a_vin),
        .b_in       (b_in),
        .b_vld_in   (b_vin),
        .a_out      (a_fwd[i][j]),
        .a_vld_out  (a_fwd_v[i][j]),
        .b_out      (b_fwd[i][j]),
        .b_vld_out  (b_fwd_v[i][j]),
        .acc        (acc_w[i][j]),
        .sat        (sat_w[i][j])
      );
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.c         = c_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
